// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fq_state_e;

  localparam logic [31:0] NOP           = 32'h0000_0013;
  localparam logic [31:0] ENTRY_DEFAULT = 32'h0000_0028;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bus: instruction-memory port, redirect input and decode handshake.
interface fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        ins_ready;

  modport master (
    output mem_req, mem_addr, ins_valid, ins, pc,
    input  mem_rdata, redirect, redirect_pc, ins_ready
  );

  modport slave (
    input  mem_req, mem_addr, ins_valid, ins, pc,
    output mem_rdata, redirect, redirect_pc, ins_ready
  );
endinterface

// File: rtl/fq_fifo.sv
// Circular buffer of {pc, instruction} entries with push, pop and a clear
// that takes priority over both.
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  assign dout = mem[rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers responses,
// flushes on redirect. FETCH_QUEUE_BYPASS_EN enables empty-queue bypass.
//
// state | meaning
// BOOT  | one idle cycle after reset release
// RUN   | fetching while queue has credit
// FLUSH | one dead cycle after redirect; fetch_pc already holds redirect_pc
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter logic [31:0] ENTRY = ENTRY_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_e   state;
  fq_state_e   state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] resp_addr;
  logic        inflight;
  logic        mem_req;
  logic [CW:0] occupancy;
  logic        resp_live;
  logic        push;
  logic        pop;
  logic        q_valid;
  logic [CW-1:0] count;
  logic [63:0] head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BOOT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     state_nx = bus.redirect ? FLUSH : RUN;
      FLUSH:   state_nx = bus.redirect ? FLUSH : RUN;
      default: state_nx = BOOT;
    endcase
  end

  // Credit counts queued plus in-flight entries; a same-cycle pop gives none.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    mem_req   = (state == RUN) && !bus.redirect
                && (occupancy < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc  <= ENTRY;
      resp_addr <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= mem_req;
      if (mem_req) resp_addr <= fetch_pc;
      if (bus.redirect)  fetch_pc <= word_align(bus.redirect_pc);
      else if (mem_req)  fetch_pc <= fetch_pc + 32'd4;
    end
  end

  assign resp_live = inflight && !bus.redirect;
  assign q_valid   = (count != '0);
  assign pop       = q_valid && bus.ins_ready && !bus.redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass        = resp_live && !q_valid;
    push          = resp_live && !(bypass && bus.ins_ready);
    bus.ins_valid = q_valid || bypass;
    if (q_valid) begin
      bus.ins = head[31:0];
      bus.pc  = head[63:32];
    end else if (bypass) begin
      bus.ins = bus.mem_rdata;
      bus.pc  = resp_addr;
    end else begin
      bus.ins = NOP;
      bus.pc  = '0;
    end
  end
`else
  always_comb begin
    push          = resp_live;
    bus.ins_valid = q_valid;
    bus.ins       = q_valid ? head[31:0]  : NOP;
    bus.pc        = q_valid ? head[63:32] : 32'd0;
  end
`endif

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = fetch_pc;

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (bus.redirect),
    .push  (push),
    .pop   (pop),
    .din   ({resp_addr, bus.mem_rdata}),
    .dout  (head),
    .count (count)
  );

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter ENTRY, default 32'h28, fetch address after reset.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: mem_req  out  1  instruction-memory read request this cycle.
REQ-006 SHALL have ports: mem_addr  out  32  word-aligned fetch address.
REQ-007 SHALL have ports: mem_rdata  in  32  instruction word, valid exactly one cycle after mem_req.
REQ-008 SHALL have ports: redirect  in  1  branch/jump/interrupt redirect from PC logic.
REQ-009 SHALL have ports: redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-010 SHALL have ports: ins_valid  out  1  head entry available to decode.
REQ-011 SHALL have ports: ins  out  32  head instruction; 32'h00000013 (NOP) when empty.
REQ-012 SHALL have ports: pc  out  32  address of head instruction; 0 when empty.
REQ-013 SHALL have ports: ins_ready  in  1  decode accepts head; pop when ins_valid&ins_ready.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, FLUSH; BOOT->RUN unconditionally after one cycle; RUN->FLUSH on redirect; FLUSH->RUN after one cycle, or stay FLUSH if redirect again.
REQ-015 SHALL assert mem_req only in RUN, with redirect=0, and count+inflight < DEPTH (no pop credit).
REQ-016 SHALL drive mem_addr = fetch_pc; fetch_pc += 4 on each mem_req, wrapping 32'hFFFFFFFC -> 0.
REQ-017 SHALL push {mem_addr of previous cycle, mem_rdata} one cycle after mem_req unless killed.
REQ-018 SHALL, on redirect, empty queue, kill any in-flight response, set fetch_pc = redirect_pc next edge.
REQ-019 SHALL give redirect priority over simultaneous pop and push; both discarded.
REQ-020 SHALL allow simultaneous push and pop; count unchanged; order preserved.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-022 SHALL present head combinationally from storage; ins_valid = (count != 0).
REQ-023 SHALL ignore ins_ready when ins_valid=0.
REQ-024 SHALL make the first request after redirect at the cycle following FLUSH, address redirect_pc.

Reset
REQ-025 SHALL, with rstn=0, asynchronously force: state BOOT, count 0, pointers 0, inflight 0, fetch_pc ENTRY, mem_req 0, ins_valid 0, ins NOP, pc 0.
REQ-026 SHALL, on reset mid-operation, discard queue contents and any in-flight response.
REQ-027 SHALL issue first mem_req (addr ENTRY) two edges after rstn rises (BOOT, then RUN).

Configuration
REQ-028 SHALL honour macro FETCH_QUEUE_BYPASS_EN: defined -> when queue empty, a non-killed response drives ins_valid/ins/pc in the same cycle and is not stored if ins_ready=1; undefined -> every response is stored, earliest ins_valid one cycle after arrival.
REQ-029 SHALL keep identical flush, ordering and reset behaviour in both configurations.

Structure
REQ-030 SHALL place state enum (BOOT/RUN/FLUSH), NOP constant 32'h00000013 and default ENTRY in package fetch_queue_pkg.
REQ-031 SHALL implement storage/pointers in one sub-module fq_fifo (DEPTH x 64 bits, push/pop/clear); FSM and fetch_pc in fetch_queue.

Verification
REQ-032 SHALL cover: release rstn, ins_ready=0, memory returns addr-derived words -> requests at 28,2C,30,34, then mem_req=0; queue full with 4 entries, head pc=28.
REQ-033 SHALL cover: ins_ready=1 continuously -> one instruction per cycle in address order 28,2C,30,...; no gaps after fill.
REQ-034 SHALL cover: redirect=1, redirect_pc=32'h100 while 3 entries queued and one in flight -> ins_valid=0 next cycle, in-flight word dropped, next mem_addr=100, first delivered pc=100.
REQ-035 SHALL cover: redirect and ins_ready same cycle -> no extra pop; next delivered pc = redirect_pc.
REQ-036 SHALL cover: redirect_pc=32'hFFFFFFFC -> fetches FFFFFFFC then 00000000.
REQ-037 SHALL cover: rstn low mid-run with full queue -> outputs at reset values immediately, no clock needed; restart at 28; repeat with/without FETCH_QUEUE_BYPASS_EN checking 0- vs 1-cycle empty-queue latency.
